// File: rtl/prog_counter.sv
`timescale 1ns / 1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : prog_counter
// Brief    : Fetch-stage PC with start/halt sequencing, BNE resolution and a
//            saturating retired-instruction counter.
// Revision : 1.0
// ----------------------------------------------------------------------------
module prog_counter #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             Zero,
  input  logic [PC_W-1:0]  Target,
  input  logic             Stall,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             running_q, done_q;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A stalled instruction has not executed, so its decode inputs are moot.
        if (!Stall) begin
          cnt_d = cnt_inc;
          if (Halt) begin
            state_d = S_DONE;
          end else if (BranchEn && !Zero) begin
            pc_d = Target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign PC        = pc_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign InstCount = cnt_q;

endmodule
`default_nettype wire

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Fetch-stage program counter for the 8-bit custom CPU. It sits directly upstream of the ALU.
- It generates the instruction address each cycle and sequences program start, halt and completion.
- It resolves BNE branches using the ALU Zero flag produced in the same cycle.
- It keeps a retired-instruction counter for performance reporting.

Parameters:
PC_W, 10, width of the program counter and instruction address.
CNT_W, 16, width of the retired-instruction counter.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset_n  input  1  synchronous, active-low reset.
Start  input  1  begin execution at StartAddr; sampled in IDLE/DONE only.
StartAddr  input  PC_W  first instruction address loaded on Start.
Halt  input  1  decoder: instruction at PC is a halt.
BranchEn  input  1  decoder: instruction at PC is BNE.
Zero  input  1  ALU Zero flag for the current instruction (combinational, same cycle).
Target  input  PC_W  absolute branch target for the current BNE.
Stall  input  1  hold the current instruction (memory wait); nothing retires.
PC  output  PC_W  current instruction address.
Running  output  1  high while in RUN.
Done  output  1  high while in DONE.
InstCount  output  CNT_W  retired instructions since last Start; saturating.

Behaviour:
- Clock and reset: one clock domain, Clk. Reset_n is synchronous and active-low.
  - While Reset_n=0 at an edge: state=IDLE, PC=0, Running=0, Done=0, InstCount=0.
  - Reset has priority over every other input, including a Start in the same cycle.
  - Reset mid-RUN aborts the program immediately; no Done pulse is produced.
- States: IDLE, RUN, DONE. Running and Done are registered decodes of the state (Running = state RUN, Done = state DONE).
- IDLE:
  - Start=1 -> PC<=StartAddr, InstCount<=0, state<=RUN.
  - Otherwise hold all outputs.
- RUN: one instruction per cycle. Decision priority is Stall > Halt > branch > increment.
  - Stall=1: PC, InstCount and state hold. Halt, BranchEn, Zero and Target are ignored that cycle.
  - Halt=1: state<=DONE, PC holds on the halt address, InstCount increments. Halt counts as retired.
  - BranchEn=1 and Zero=0 (BNE taken): PC<=Target, InstCount increments.
  - BranchEn=1 and Zero=1 (not taken): PC<=PC+1, InstCount increments.
  - Otherwise PC<=PC+1, InstCount increments.
  - PC+1 wraps modulo 2^PC_W (all-ones -> 0) with no flag. Target is used unmodified.
  - Start is ignored in RUN.
- DONE:
  - Done=1, PC and InstCount hold until Start.
  - Start=1 -> same action as in IDLE. Done drops and Running rises at the next edge.
- InstCount saturates at 2^CNT_W-1; it never wraps.
- Latency: the address is visible on PC the cycle after the decision.
  - Start -> first instruction address on PC: 1 cycle.
  - Halt -> Done high: 1 cycle.
- All outputs are registered. No combinational path from any input to any output.

Test Plan:
1. Reset and start: hold Reset_n=0 with Start=1 -> PC=0, IDLE, Running=0, Done=0, InstCount=0. Release, Start=1 with StartAddr=0x005 -> next cycle PC=0x005, Running=1.
2. Sequential run with wrap: StartAddr=0x3FE, no branch or halt for 3 cycles -> PC goes 0x3FE, 0x3FF, 0x000, 0x001; InstCount=3.
3. BNE: at PC=0x010, BranchEn=1, Zero=0, Target=0x004 -> PC=0x004. Repeat with Zero=1 -> PC=0x011. Both cases increment InstCount.
4. Stall priority: Stall=1 for 2 cycles with Halt=1 and BranchEn=1, Zero=0 asserted -> PC, InstCount and state unchanged. Release Stall with Halt=1 -> Done=1 next cycle, PC unchanged.
5. Halt and restart: 4 instructions then Halt -> Done=1, InstCount=5. Start in DONE with StartAddr=0x020 -> Done=0, Running=1, PC=0x020, InstCount=0. Start pulsed mid-RUN -> no effect.
6. Saturation and mid-run reset: CNT_W=4, run 20 instructions -> InstCount=15 and holds. Assert Reset_n=0 mid-RUN -> IDLE, PC=0, InstCount=0, Done never asserted.
